branch_predictor: RTL

- Fetch-stage dynamic branch predictor. It produces the prediction that the hazard unit consumes as prediction_E.
- Looks up PCF in a direct-mapped table of 2-bit saturating counters and a branch target buffer (BTB), and drives a predicted-taken flag and target to the PC mux.
- Carries each prediction down the F→D→E pipeline under the same stall/flush controls as the datapath.
- Trains on the resolved branch outcome in Execute.

---
 rtl/branch_predictor.sv | 107 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped 2-bit counter table plus BTB,
// with the prediction carried F->D->E and trained from the resolved branch in Execute.
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PCF,
    output logic              PredictTakenF,
    output logic [ADDR_W-1:0] PredTargetF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    output logic              prediction_E,
    output logic [ADDR_W-1:0] PredTargetE,
    input  logic              BranchE,
    input  logic              BranchTakenE_for_predictor,
    input  logic [ADDR_W-1:0] PCE,
    input  logic [ADDR_W-1:0] BranchTargetE
);

    localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
    localparam int          TAG_W   = ADDR_W - INDEX_BITS - 2;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [ADDR_W-1:0] r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];

    logic              r_pred_d;
    logic [ADDR_W-1:0] r_tgt_d;
    logic              r_pred_e;
    logic [ADDR_W-1:0] r_tgt_e;

    logic [INDEX_BITS-1:0] w_idx_f;
    logic [TAG_W-1:0]      w_tag_f;
    logic [INDEX_BITS-1:0] w_idx_e;
    logic [TAG_W-1:0]      w_tag_e;
    logic                  w_hit_f;
    logic                  w_unused_lsbs;

    assign w_idx_f       = PCF[INDEX_BITS+1:2];
    assign w_tag_f       = PCF[ADDR_W-1:INDEX_BITS+2];
    assign w_idx_e       = PCE[INDEX_BITS+1:2];
    assign w_tag_e       = PCE[ADDR_W-1:INDEX_BITS+2];
    assign w_unused_lsbs = ^{PCF[1:0], PCE[1:0]};

    // Lookup sees pre-update contents; a same-cycle update is visible next cycle.
    always_comb begin
        w_hit_f       = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
        PredictTakenF = w_hit_f && r_ctr[w_idx_f][1];
        PredTargetF   = w_hit_f ? r_target[w_idx_f] : '0;
    end

    // Counters are per index: a BTB replacement on a taken branch keeps the counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (BranchE) begin
            if (BranchTakenE_for_predictor) begin
                if (r_ctr[w_idx_e] != 2'b11)
                    r_ctr[w_idx_e] <= r_ctr[w_idx_e] + 2'b01;
                r_valid[w_idx_e]  <= 1'b1;
                r_tag[w_idx_e]    <= w_tag_e;
                r_target[w_idx_e] <= BranchTargetE;
            end else if (r_ctr[w_idx_e] != 2'b00) begin
                r_ctr[w_idx_e] <= r_ctr[w_idx_e] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pred_d <= 1'b0;
            r_tgt_d  <= '0;
        end else if (FlushD) begin
            r_pred_d <= 1'b0;
            r_tgt_d  <= '0;
        end else if (!StallD) begin
            r_pred_d <= PredictTakenF;
            r_tgt_d  <= PredTargetF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pred_e <= 1'b0;
            r_tgt_e  <= '0;
        end else if (FlushE) begin
            r_pred_e <= 1'b0;
            r_tgt_e  <= '0;
        end else begin
            r_pred_e <= r_pred_d;
            r_tgt_e  <= r_tgt_d;
        end
    end

    assign prediction_E = r_pred_e;
    assign PredTargetE  = r_tgt_e;

endmodule
